// File: rtl/ofdm_tx_framer.sv
// OFDM transmit framer: one BPSK training symbol, then DATASYMS QPSK data symbols per frame.
// Define OFDM_TX_SCRAMBLE_EN to whiten data_i with an x^7+x^4+1 LFSR before mapping.
module ofdm_tx_framer #(
  parameter int unsigned DATAWIDTH  = 16,
  parameter int unsigned FFT        = 64,
  parameter int unsigned DATASYMS   = 12,
  parameter int unsigned SYM_PERIOD = 5,
  parameter int unsigned QPSK_AMP   = 11585,
  parameter int unsigned TRAIN_AMP  = 16384,
  parameter logic [63:0] TRAIN_SEQ  = 64'hA5F03C960F5AC369
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [103:0]             data_i,
  input  logic                     data_valid_i,
  output logic                     data_ready_o,
  output logic [DATAWIDTH*FFT-1:0] sym_re_o,
  output logic [DATAWIDTH*FFT-1:0] sym_im_o,
  output logic                     sym_valid_o,
  output logic                     sym_train_o,
  output logic                     sym_last_o,
  output logic                     busy_o,
  output logic                     underrun_o
);

  localparam int unsigned TW = (SYM_PERIOD > 2) ? $clog2(SYM_PERIOD) : 1;
  localparam int unsigned IW = $clog2(DATASYMS + 1);
  localparam logic [TW-1:0] TimerMax = TW'(SYM_PERIOD - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DATASYMS - 1);

  localparam logic [DATAWIDTH-1:0] QPos = DATAWIDTH'(QPSK_AMP);
  localparam logic [DATAWIDTH-1:0] QNeg = ~QPos + 1'b1;
  localparam logic [DATAWIDTH-1:0] TPos = DATAWIDTH'(TRAIN_AMP);
  localparam logic [DATAWIDTH-1:0] TNeg = ~TPos + 1'b1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StTrain = 2'd1;
  localparam logic [1:0] StData  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     ready_q, ready_d;
  logic [DATAWIDTH*FFT-1:0] re_q, re_d, im_q, im_d;
  logic                     valid_q, valid_d;
  logic                     train_q, train_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     underrun_q, underrun_d;

  logic                     start_acc, hs;
  logic [103:0]             word;
  logic [DATAWIDTH*FFT-1:0] train_re, data_re, data_im;

  assign start_acc = (state_q == StIdle) && start_i;
  assign hs        = (state_q == StData) && ready_q && data_valid_i;

`ifdef OFDM_TX_SCRAMBLE_EN
  logic [6:0] lfsr_q, lfsr_d, lfsr_adv;

  // Whiten bit0 first; the state after 104 steps is kept for the next word.
  always_comb begin
    logic [6:0] x;
    logic       s;
    x    = lfsr_q;
    s    = 1'b0;
    word = '0;
    for (int i = 0; i < 104; i++) begin
      s       = x[6] ^ x[3];
      word[i] = data_i[i] ^ s;
      x       = {x[5:0], s};
    end
    lfsr_adv = x;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (start_acc) begin
      lfsr_d = 7'h7F;
    end else if (hs) begin
      lfsr_d = lfsr_adv;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lfsr_q <= 7'h7F;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign word = data_i;
`endif

  // Null bins are DC and 27..37; active bin n maps to data bits 2n (re) and 2n+1 (im).
  always_comb begin
    int n;
    n        = 0;
    train_re = '0;
    data_re  = '0;
    data_im  = '0;
    for (int k = 0; k < FFT; k++) begin
      if (k != 0 && (k < 27 || k > 37)) begin
        n = (k < 27) ? k - 1 : k - 12;
        train_re[k*DATAWIDTH +: DATAWIDTH] = TRAIN_SEQ[k] ? TNeg : TPos;
        data_re[k*DATAWIDTH +: DATAWIDTH]  = word[2*n] ? QNeg : QPos;
        data_im[k*DATAWIDTH +: DATAWIDTH]  = word[2*n+1] ? QNeg : QPos;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    re_d       = re_q;
    im_d       = im_q;
    valid_d    = 1'b0;
    train_d    = 1'b0;
    last_d     = 1'b0;
    underrun_d = underrun_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StTrain;
          timer_d    = '0;
          idx_d      = '0;
          underrun_d = 1'b0;
          re_d       = train_re;
          im_d       = '0;
          valid_d    = 1'b1;
          train_d    = 1'b1;
        end
      end
      StTrain: begin
        state_d = StData;
        timer_d = TW'(1);
      end
      StData: begin
        if (last_q) begin
          // Last data symbol is on the outputs this cycle; frame ends after it.
          state_d = StIdle;
          timer_d = '0;
        end else if (hs) begin
          timer_d = '0;
          idx_d   = idx_q + 1'b1;
          re_d    = data_re;
          im_d    = data_im;
          valid_d = 1'b1;
          last_d  = (idx_q == IdxLast);
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + 1'b1;
        end else if (!data_valid_i) begin
          underrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StData) && (timer_d == TimerMax);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
      valid_q    <= 1'b0;
      train_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      re_q       <= re_d;
      im_q       <= im_d;
      valid_q    <= valid_d;
      train_q    <= train_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign data_ready_o = ready_q;
  assign sym_re_o     = re_q;
  assign sym_im_o     = im_q;
  assign sym_valid_o  = valid_q;
  assign sym_train_o  = train_q;
  assign sym_last_o   = last_q;
  assign busy_o       = busy_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_ofdm_tx_framer.sv
// Randomized bench for ofdm_tx_framer: a frame-level schedule/symbol model predicts every cycle.
module tb_ofdm_tx_framer;
  localparam int DW   = 16;
  localparam int NB   = 64;
  localparam int NS   = 12;
  localparam int SP   = 5;
  localparam int VW   = DW * NB;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [103:0]  data = '0;
  logic          dvalid = 1'b0;
  logic          dready;
  logic [VW-1:0] sym_re, sym_im;
  logic          sym_valid, sym_train, sym_last, busy, underrun;

  ofdm_tx_framer dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .data_i      (data),
    .data_valid_i(dvalid),
    .data_ready_o(dready),
    .sym_re_o    (sym_re),
    .sym_im_o    (sym_im),
    .sym_valid_o (sym_valid),
    .sym_train_o (sym_train),
    .sym_last_o  (sym_last),
    .busy_o      (busy),
    .underrun_o  (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0]   tseq = 64'hA5F03C960F5AC369;
  int            act[52];
  logic [VW-1:0] train_vec;
  logic [VW-1:0] exp_re = '0, exp_im = '0;

  // Per-frame stimulus and predicted schedule
  bit            vld[MAXC];
  bit            stq[MAXC];
  logic [103:0]  dat[MAXC];
  int            eslot[NS], hs[NS];
  logic [VW-1:0] ere[NS], eim[NS];
  int            first_stall, s_last;

  function automatic void map_word(input logic [103:0] w, output logic [VW-1:0] re,
                                   output logic [VW-1:0] im);
    re = '0;
    im = '0;
    for (int n = 0; n < 52; n++) begin
      re[act[n]*DW +: DW] = w[2*n] ? 16'hD2BF : 16'd11585;
      im[act[n]*DW +: DW] = w[2*n+1] ? 16'hD2BF : 16'd11585;
    end
  endfunction

  function automatic logic [103:0] scramble(input logic [103:0] w, inout logic [6:0] st);
    logic [103:0] o;
    logic         s;
    o = w;
`ifdef OFDM_TX_SCRAMBLE_EN
    for (int i = 0; i < 104; i++) begin
      s    = st[6] ^ st[3];
      o[i] = w[i] ^ s;
      st   = {st[5:0], s};
    end
`else
    s = 1'b0;
    st = st ^ {6'd0, s};
`endif
    return o;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, VW'(dready), VW'(0));
    check({tag, "_re"}, sym_re, '0);
    check({tag, "_im"}, sym_im, '0);
    check({tag, "_valid"}, VW'(sym_valid), VW'(0));
    check({tag, "_train"}, VW'(sym_train), VW'(0));
    check({tag, "_last"}, VW'(sym_last), VW'(0));
    check({tag, "_busy"}, VW'(busy), VW'(0));
    check({tag, "_underrun"}, VW'(underrun), VW'(0));
  endtask

  // mode 0: zeros always valid; 1: ones always valid; 2: 3-cycle stall at slot 2; 3: random
  task automatic run_frame(input int mode, input int abort_at);
    logic [127:0] r;
    logic [6:0]   st;
    logic [103:0] w;
    int           e, h;
    bit           x_valid, x_ready;
    for (int c = 0; c < MAXC; c++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      case (mode)
        0: begin vld[c] = 1'b1; dat[c] = '0; end
        1: begin vld[c] = 1'b1; dat[c] = '1; end
        2: begin vld[c] = !(c >= 2*SP && c < 2*SP + 3); dat[c] = r[103:0]; end
        default: begin vld[c] = ($urandom_range(0, 4) != 0); dat[c] = r[103:0]; end
      endcase
      if (c >= 300) vld[c] = 1'b1;
      stq[c] = (mode >= 2) && ($urandom_range(0, 7) == 0);
    end
    e = SP;
    first_stall = MAXC;
    st = 7'h7F;
    for (int j = 0; j < NS; j++) begin
      h = e;
      while (!vld[h] && h < MAXC - 3) h++;
      if (h > e && first_stall == MAXC) first_stall = e;
      eslot[j] = e;
      hs[j] = h;
      w = scramble(dat[h], st);
      map_word(w, ere[j], eim[j]);
      e = h + SP;
    end
    s_last = hs[NS-1] + 1;

    @(posedge clk);
    for (int c = 0; c <= s_last + 1; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      start  = (c == 0) || (c >= 1 && c <= s_last && stq[c]);
      dvalid = vld[c];
      data   = dat[c];
      @(negedge clk);
      x_valid = (c == 1);
      x_ready = 1'b0;
      if (c == 1) begin
        exp_re = train_vec;
        exp_im = '0;
      end
      for (int j = 0; j < NS; j++) begin
        if (c == hs[j] + 1) begin
          x_valid = 1'b1;
          exp_re = ere[j];
          exp_im = eim[j];
        end
        if (c >= eslot[j] && c <= hs[j]) x_ready = 1'b1;
      end
      check($sformatf("m%0d_c%0d_valid", mode, c), VW'(sym_valid), VW'(x_valid));
      check($sformatf("m%0d_c%0d_train", mode, c), VW'(sym_train), VW'(c == 1));
      check($sformatf("m%0d_c%0d_last", mode, c), VW'(sym_last), VW'(c == s_last));
      check($sformatf("m%0d_c%0d_busy", mode, c), VW'(busy), VW'(c >= 1 && c <= s_last));
      check($sformatf("m%0d_c%0d_ready", mode, c), VW'(dready), VW'(x_ready));
      check($sformatf("m%0d_c%0d_re", mode, c), sym_re, exp_re);
      check($sformatf("m%0d_c%0d_im", mode, c), sym_im, exp_im);
      if (c >= 1)
        check($sformatf("m%0d_c%0d_underrun", mode, c), VW'(underrun), VW'(c > first_stall));
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        start  = 1'b0;
        dvalid = 1'b0;
        exp_re = '0;
        exp_im = '0;
        return;
      end
    end
    #1;
    start  = 1'b0;
    dvalid = 1'b0;
  endtask

  initial begin
    int n;
    n = 0;
    for (int k = 1; k < NB; k++) begin
      if (k < 27 || k > 37) begin
        act[n] = k;
        n++;
      end
    end
    train_vec = '0;
    for (int k = 0; k < NB; k++) begin
      if (k != 0 && (k < 27 || k > 37)) train_vec[k*DW +: DW] = tseq[k] ? 16'hC000 : 16'h4000;
    end

    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(3, 23);
    repeat (2) @(posedge clk);
    for (int f = 0; f < 5; f++) run_frame(3, -1);
    run_frame(0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
